// File: rtl/scytale_encryption_if.sv
// Bus between a plaintext source and the scytale encryption block.
//
// Handshake: a character or the start token is transferred on every rising
// clk edge where valid_i is high and busy is low. There is no ready signal.
// While busy is high, valid_i and data_i are ignored and nothing is stored.
// On the output side, data_o is a ciphertext character exactly when valid_o
// is high, and data_o is 0 whenever valid_o is low. The sink cannot stall
// the output. fsm_state mirrors the controller state: 0 = IDLE, 1 = ENCRYPT.
interface scytale_encryption_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 fsm_state;

  modport master (
    output data_i, valid_i, key_N, key_M,
    input  busy, data_o, valid_o, fsm_state
  );

  modport slave (
    input  data_i, valid_i, key_N, key_M,
    output busy, data_o, valid_o, fsm_state
  );
endinterface

// File: rtl/scytale_encryption.sv
// Scytale transposition cipher.
// In IDLE the block collects plaintext characters into a buffer. A start
// token with a non-empty buffer latches the key. In ENCRYPT the block emits
// the M x N row-major matrix in column-major order, one character per cycle.
// Matrix positions beyond the stored text are emitted as zero padding.
module scytale_encryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scytale_encryption_if.slave  bus
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int LW = 2 * KEY_WIDTH;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NOF_CHARS);

  typedef enum logic {
    IDLE    = 1'b0,
    ENCRYPT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [D_WIDTH-1:0]   char_buf [MAX_NOF_CHARS];
  logic [CW-1:0]        count_q;
  logic [KEY_WIDTH-1:0] n_q;
  logic [KEY_WIDTH-1:0] m_q;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        beat_q;
  logic [KEY_WIDTH-1:0] row_q;
  logic [KEY_WIDTH-1:0] col_q;
  logic [LW-1:0]        idx_q;

  logic                 take_char;
  logic                 take_token;
  logic                 emit;
  logic                 finish;
  logic [D_WIDTH-1:0]   rd_char;

  // Next-state logic and per-cycle qualifiers for the datapath.
  always_comb begin
    state_d    = state_q;
    take_char  = 1'b0;
    take_token = 1'b0;
    emit       = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.data_i != START_ENCRYPTION_TOKEN) begin
            take_char = 1'b1;
          end else if (count_q != '0) begin
            take_token = 1'b1;
            state_d    = ENCRYPT;
          end
        end
      end
      ENCRYPT: begin
        if (beat_q < len_q) begin
          emit = 1'b1;
        end else begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer read: indices past the stored text become padding, which also
  // keeps stale entries from before a reset or an earlier message hidden.
  always_comb begin
    rd_char = '0;
    if (idx_q < LW'(count_q)) begin
      rd_char = char_buf[idx_q[AW-1:0]];
    end
  end

  // Plaintext storage; not reset, stale contents are masked by the count.
  always_ff @(posedge clk) begin
    if (take_char && (count_q < MAX_CNT)) begin
      char_buf[count_q[AW-1:0]] <= bus.data_i;
    end
  end

  // State register, counters, latched key and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus.busy    <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      count_q     <= '0;
      n_q         <= '0;
      m_q         <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus.busy    <= (state_d == ENCRYPT);
      bus.valid_o <= emit;
      bus.data_o  <= emit ? rd_char : '0;

      // Saturating character count; overflow characters are dropped.
      if (take_char && (count_q < MAX_CNT)) begin
        count_q <= count_q + 1'b1;
      end

      // Key is frozen for the whole message once the token is accepted.
      if (take_token) begin
        n_q    <= bus.key_N;
        m_q    <= bus.key_M;
        len_q  <= LW'(bus.key_N) * LW'(bus.key_M);
        beat_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
        idx_q  <= '0;
      end

      // Walk down a column (idx += N); at the bottom wrap to the next column
      // top, whose index is simply the new column number.
      if (emit) begin
        beat_q <= beat_q + 1'b1;
        if ((row_q + 1'b1) < m_q) begin
          row_q <= row_q + 1'b1;
          idx_q <= idx_q + LW'(n_q);
        end else begin
          row_q <= '0;
          col_q <= col_q + 1'b1;
          idx_q <= LW'(col_q) + 1'b1;
        end
      end

      if (finish) begin
        count_q <= '0;
      end
    end
  end

  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Directed bench for scytale_encryption with hand-computed ciphertext.
module tb_scytale_encryption;

  localparam logic [7:0] TOKEN = 8'hFA;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Clock and interface
  always #5 clk = ~clk;

  scytale_encryption_if #(.D_WIDTH(8), .KEY_WIDTH(8)) bus ();

  scytale_encryption #(
    .D_WIDTH(8),
    .KEY_WIDTH(8),
    .MAX_NOF_CHARS(50),
    .START_ENCRYPTION_TOKEN(8'hFA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic send_char(input logic [7:0] c);
    bus.valid_i = 1'b1;
    bus.data_i  = c;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
  endtask

  task automatic fire(input logic [7:0] n, input logic [7:0] m);
    bus.key_N   = n;
    bus.key_M   = m;
    bus.valid_i = 1'b1;
    bus.data_i  = TOKEN;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
  endtask

  // Called in the cycle right after the token edge; checks every beat
  // against exp_q and the cycle where busy drops.
  task automatic collect(input string name, input int len, input bit inject);
    logic [7:0] e;
    check({name, "_start_busy"}, bus.busy, 1);
    check({name, "_start_valid"}, bus.valid_o, 0);
    check({name, "_start_data"}, bus.data_o, 0);
    for (int k = 0; k < len; k++) begin
      if (inject) begin
        bus.valid_i = 1'b1;
        bus.data_i  = k[0] ? TOKEN : 8'h58;
        bus.key_N   = 8'($urandom_range(0, 255));
        bus.key_M   = 8'($urandom_range(0, 255));
      end
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s_beat%0d_valid", name, k), bus.valid_o, 1);
      check($sformatf("%s_beat%0d_data", name, k), bus.data_o, e);
      check($sformatf("%s_beat%0d_busy", name, k), bus.busy, 1);
    end
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    tick();
    check({name, "_end_busy"}, bus.busy, 0);
    check({name, "_end_valid"}, bus.valid_o, 0);
    check({name, "_end_data"}, bus.data_o, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.key_N   = 8'd0;
    bus.key_M   = 8'd0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_state", bus.fsm_state, 0);
    rst_n = 1'b1;
    tick();

    // ABCDEF, 3 columns x 2 rows
    for (int i = 0; i < 6; i++) send_char(8'h41 + 8'(i));
    exp_q = '{8'h41, 8'h44, 8'h42, 8'h45, 8'h43, 8'h46};
    fire(8'd3, 8'd2);
    collect("abcdef", 6, 1'b0);

    // ABCD, same key: short text padded with zeros
    for (int i = 0; i < 4; i++) send_char(8'h41 + 8'(i));
    exp_q = '{8'h41, 8'h44, 8'h42, 8'h00, 8'h43, 8'h00};
    fire(8'd3, 8'd2);
    collect("abcd", 6, 1'b0);

    // Token on an empty buffer is ignored
    fire(8'd3, 8'd2);
    check("empty_busy0", bus.busy, 0);
    check("empty_valid0", bus.valid_o, 0);
    tick();
    check("empty_busy1", bus.busy, 0);
    check("empty_valid1", bus.valid_o, 0);
    check("empty_state", bus.fsm_state, 0);

    // Zero-length key: one busy cycle, no output, buffer cleared
    send_char(8'h41);
    fire(8'd0, 8'd3);
    check("zero_len_busy", bus.busy, 1);
    check("zero_len_valid", bus.valid_o, 0);
    tick();
    check("zero_len_end_busy", bus.busy, 0);
    check("zero_len_end_valid", bus.valid_o, 0);
    fire(8'd2, 8'd2);
    check("zero_len_cleared", bus.busy, 0);

    // 60 characters, only 50 kept; 10 columns x 5 rows
    for (int i = 0; i < 60; i++) send_char(8'(i + 1));
    for (int k = 0; k < 50; k++) exp_q.push_back(8'((k % 5) * 10 + (k / 5) + 1));
    fire(8'd10, 8'd5);
    collect("sat50", 50, 1'b0);

    // Input and key changes during busy are ignored
    send_char(8'h41);
    send_char(8'h42);
    exp_q = '{8'h41, 8'h42};
    fire(8'd2, 8'd1);
    collect("inject", 2, 1'b1);
    fire(8'd2, 8'd2);
    check("inject_next_empty", bus.busy, 0);
    tick();
    check("inject_next_valid", bus.valid_o, 0);

    // Reset on the third output beat
    for (int i = 0; i < 6; i++) send_char(8'h41 + 8'(i));
    fire(8'd3, 8'd2);
    check("abort_start_busy", bus.busy, 1);
    tick();
    check("abort_beat0", bus.data_o, 8'h41);
    tick();
    check("abort_beat1", bus.data_o, 8'h44);
    tick();
    check("abort_beat2", bus.data_o, 8'h42);
    check("abort_beat2_valid", bus.valid_o, 1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.valid_o, 0);
    check("abort_data", bus.data_o, 0);
    check("abort_state", bus.fsm_state, 0);
    rst_n = 1'b1;
    tick();
    check("abort_quiet_valid", bus.valid_o, 0);
    check("abort_quiet_busy", bus.busy, 0);

    // 2x2 message after the aborted one
    for (int i = 0; i < 4; i++) send_char(8'h57 + 8'(i));
    exp_q = '{8'h57, 8'h59, 8'h58, 8'h5A};
    fire(8'd2, 8'd2);
    collect("wxyz", 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
